// File: rtl/tdm_demux.sv
// tdm_demux: receive side of a NUM_CH-slot TDM word stream; aligns on a channel-0 sync marker
// and presents whole frames in parallel. Define TDM_DEMUX_PARITY_EN to add the even-parity check.
module tdm_demux #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sync,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     err_clr,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic                     in_par,
  output logic                     par_err,
`endif
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     out_valid,
  output logic                     locked,
  output logic                     frame_err
);

  localparam int CW = $clog2(NUM_CH);
  localparam logic [CW-1:0] LAST = CW'(NUM_CH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t                        state;
  logic [CW-1:0]                 cnt;
  logic [(NUM_CH-1)*DATA_W-1:0]  shadow;

`ifdef TDM_DEMUX_PARITY_EN
  logic word_bad;
  assign word_bad = ^{in_data, in_par};
`endif

  assign locked = (state == LOCKED);

  // Slots 0..NUM_CH-2 collect in the shadow; the last word is merged straight into out_data
  // so a partial frame is never visible on the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      cnt       <= '0;
      shadow    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      // Clear first so that an error raised later in this cycle wins.
      if (err_clr) begin
        frame_err <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        par_err   <= 1'b0;
`endif
      end
      if (in_valid) begin
`ifdef TDM_DEMUX_PARITY_EN
        if (word_bad) begin
          par_err <= 1'b1;
          state   <= HUNT;
          cnt     <= '0;
        end else
`endif
        begin
          case (state)
            LOCKED: begin
              if (in_sync) begin
                if (cnt != '0)
                  frame_err <= 1'b1;
                shadow[DATA_W-1:0] <= in_data;
                cnt                <= ONE;
              end else if (cnt == '0) begin
                frame_err <= 1'b1;
                state     <= HUNT;
              end else if (cnt == LAST) begin
                out_data  <= {in_data, shadow};
                out_valid <= 1'b1;
                cnt       <= '0;
              end else begin
                shadow[cnt*DATA_W +: DATA_W] <= in_data;
                cnt                          <= cnt + ONE;
              end
            end
            default: begin
              if (in_sync) begin
                shadow[DATA_W-1:0] <= in_data;
                cnt                <= ONE;
                state              <= LOCKED;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: table-driven check of tdm_demux (NUM_CH=4, DATA_W=8) with a frame scoreboard.
// Parity scenario is included when TDM_DEMUX_PARITY_EN is defined.
module tb_tdm_demux;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_sync;
  logic [7:0]  in_data;
  logic        err_clr;
  logic [31:0] out_data;
  logic        out_valid;
  logic        locked;
  logic        frame_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic        in_par;
  logic        par_err;
`endif

  tdm_demux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sync   (in_sync),
    .in_data   (in_data),
    .err_clr   (err_clr),
`ifdef TDM_DEMUX_PARITY_EN
    .in_par    (in_par),
    .par_err   (par_err),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .locked    (locked),
    .frame_err (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        rst;
    logic        v;
    logic        s;
    logic        clr;
    logic        badp;
    logic [7:0]  d;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic        ef;
    logic        ep;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] pending[$];
  logic [31:0] sb_exp;
  int          n_compared   = 0;
  int          n_mismatched = 0;

  function automatic vec_t mkRow(input int r, input int v, input int s, input int clr,
                                 input logic [7:0] d, input int ev, input logic [31:0] ed,
                                 input int el, input int ef);
    vec_t t;
    t.rst  = (r != 0);
    t.v    = (v != 0);
    t.s    = (s != 0);
    t.clr  = (clr != 0);
    t.badp = 1'b0;
    t.d    = d;
    t.ev   = (ev != 0);
    t.ed   = ed;
    t.el   = (el != 0);
    t.ef   = (ef != 0);
    t.ep   = 1'b0;
    return t;
  endfunction

  task automatic addRow(input int r, input int v, input int s, input int clr,
                        input logic [7:0] d, input int ev, input logic [31:0] ed,
                        input int el, input int ef);
    vecs.push_back(mkRow(r, v, s, clr, d, ev, ed, el, ef));
  endtask

  task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t t, input int idx);
    compareVal($sformatf("row%0d out_valid", idx), {31'd0, out_valid}, {31'd0, t.ev});
    compareVal($sformatf("row%0d out_data", idx), out_data, t.ed);
    compareVal($sformatf("row%0d locked", idx), {31'd0, locked}, {31'd0, t.el});
    compareVal($sformatf("row%0d frame_err", idx), {31'd0, frame_err}, {31'd0, t.ef});
`ifdef TDM_DEMUX_PARITY_EN
    compareVal($sformatf("row%0d par_err", idx), {31'd0, par_err}, {31'd0, t.ep});
`endif
  endtask

  // Drive one row, book any expected frame with the scoreboard, then check just after the edge.
  task automatic applyStimulus(input vec_t t, input int idx);
    rst      = t.rst;
    in_valid = t.v;
    in_sync  = t.s;
    in_data  = t.d;
    err_clr  = t.clr;
`ifdef TDM_DEMUX_PARITY_EN
    in_par   = (^t.d) ^ t.badp;
`endif
    if (t.ev)
      pending.push_back(t.ed);
    @(posedge clk);
    #1;
    checkOutput(t, idx);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      n_compared++;
      if (pending.size() == 0) begin
        n_mismatched++;
        $display("[TB] FAIL scoreboard: got unexpected frame %h, expected none", out_data);
      end else begin
        sb_exp = pending.pop_front();
        if (out_data !== sb_exp) begin
          n_mismatched++;
          $display("[TB] FAIL scoreboard frame: got %h, expected %h", out_data, sb_exp);
        end
      end
    end
  end

  initial begin
    logic [31:0] f1;
    logic [31:0] f2;
    int          idx;
    vec_t        t;

    f1 = 32'h44332211;
    f2 = 32'h88776655;

    // Basic frame
    addRow(0, 1, 1, 0, 8'h11, 0, 32'h0, 1, 0);
    addRow(0, 1, 0, 0, 8'h22, 0, 32'h0, 1, 0);
    addRow(0, 1, 0, 0, 8'h33, 0, 32'h0, 1, 0);
    addRow(0, 1, 0, 0, 8'h44, 1, f1,    1, 0);
    addRow(0, 0, 0, 0, 8'h00, 0, f1,    1, 0);
    // Pre-sync garbage after a reset
    addRow(1, 0, 0, 0, 8'h00, 0, 32'h0, 0, 0);
    addRow(0, 1, 0, 0, 8'hAA, 0, 32'h0, 0, 0);
    addRow(0, 1, 0, 0, 8'hBB, 0, 32'h0, 0, 0);
    addRow(0, 1, 1, 0, 8'h11, 0, 32'h0, 1, 0);
    addRow(0, 1, 0, 0, 8'h22, 0, 32'h0, 1, 0);
    addRow(0, 1, 0, 0, 8'h33, 0, 32'h0, 1, 0);
    addRow(0, 1, 0, 0, 8'h44, 1, f1,    1, 0);
    // Early sync, then err_clr
    addRow(0, 1, 1, 0, 8'h11, 0, f1, 1, 0);
    addRow(0, 1, 0, 0, 8'h22, 0, f1, 1, 0);
    addRow(0, 1, 1, 0, 8'h55, 0, f1, 1, 1);
    addRow(0, 1, 0, 0, 8'h66, 0, f1, 1, 1);
    addRow(0, 1, 0, 0, 8'h77, 0, f1, 1, 1);
    addRow(0, 1, 0, 0, 8'h88, 1, f2, 1, 1);
    addRow(0, 0, 0, 1, 8'h00, 0, f2, 1, 0);
    // Frame with idle gaps, then missing sync
    addRow(0, 1, 1, 0, 8'h11, 0, f2, 1, 0);
    addRow(0, 0, 0, 0, 8'h00, 0, f2, 1, 0);
    addRow(0, 1, 0, 0, 8'h22, 0, f2, 1, 0);
    addRow(0, 0, 0, 0, 8'h00, 0, f2, 1, 0);
    addRow(0, 1, 0, 0, 8'h33, 0, f2, 1, 0);
    addRow(0, 0, 0, 0, 8'h00, 0, f2, 1, 0);
    addRow(0, 1, 0, 0, 8'h44, 1, f1, 1, 0);
    addRow(0, 0, 0, 0, 8'h00, 0, f1, 1, 0);
    addRow(0, 1, 0, 0, 8'h99, 0, f1, 0, 1);
    addRow(0, 1, 0, 0, 8'h12, 0, f1, 0, 1);
    addRow(0, 1, 0, 0, 8'h34, 0, f1, 0, 1);
    // Relock; early sync coinciding with err_clr keeps the flag set
    addRow(0, 1, 1, 0, 8'h11, 0, f1, 1, 1);
    addRow(0, 1, 1, 1, 8'h22, 0, f1, 1, 1);
    addRow(0, 0, 0, 1, 8'h00, 0, f1, 1, 0);
    addRow(0, 1, 0, 0, 8'h33, 0, f1, 1, 0);
    addRow(0, 1, 0, 0, 8'h44, 0, f1, 1, 0);
    addRow(0, 1, 0, 0, 8'h55, 1, 32'h55443322, 1, 0);
    // Back-to-back frames
    addRow(0, 1, 1, 0, 8'hA0, 0, 32'h55443322, 1, 0);
    addRow(0, 1, 0, 0, 8'hA1, 0, 32'h55443322, 1, 0);
    addRow(0, 1, 0, 0, 8'hA2, 0, 32'h55443322, 1, 0);
    addRow(0, 1, 0, 0, 8'hA3, 1, 32'hA3A2A1A0, 1, 0);
    addRow(0, 1, 1, 0, 8'hB0, 0, 32'hA3A2A1A0, 1, 0);
    addRow(0, 1, 0, 0, 8'hB1, 0, 32'hA3A2A1A0, 1, 0);
    addRow(0, 1, 0, 0, 8'hB2, 0, 32'hA3A2A1A0, 1, 0);
    addRow(0, 1, 0, 0, 8'hB3, 1, 32'hB3B2B1B0, 1, 0);

    rst      = 1'b1;
    in_valid = 1'b0;
    in_sync  = 1'b0;
    in_data  = 8'h00;
    err_clr  = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    in_par   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checkOutput(mkRow(1, 0, 0, 0, 8'h00, 0, 32'h0, 0, 0), -1);
    rst = 1'b0;

    foreach (vecs[i])
      applyStimulus(vecs[i], i);
    idx = vecs.size();

    // Asynchronous reset in the middle of a frame
    applyStimulus(mkRow(0, 1, 1, 0, 8'h11, 0, 32'hB3B2B1B0, 1, 0), idx++);
    applyStimulus(mkRow(0, 1, 0, 0, 8'h22, 0, 32'hB3B2B1B0, 1, 0), idx++);
    in_valid = 1'b0;
    in_sync  = 1'b0;
    rst      = 1'b1;
    #1;
    compareVal("async rst out_data", out_data, 32'h0);
    compareVal("async rst out_valid", {31'd0, out_valid}, 32'h0);
    compareVal("async rst locked", {31'd0, locked}, 32'h0);
    compareVal("async rst frame_err", {31'd0, frame_err}, 32'h0);
    #1;
    rst = 1'b0;
    applyStimulus(mkRow(0, 1, 0, 0, 8'h33, 0, 32'h0, 0, 0), idx++);
    applyStimulus(mkRow(0, 1, 1, 0, 8'h11, 0, 32'h0, 1, 0), idx++);
    applyStimulus(mkRow(0, 1, 0, 0, 8'h22, 0, 32'h0, 1, 0), idx++);
    applyStimulus(mkRow(0, 1, 0, 0, 8'h33, 0, 32'h0, 1, 0), idx++);
    applyStimulus(mkRow(0, 1, 0, 0, 8'h44, 1, f1,    1, 0), idx++);

`ifdef TDM_DEMUX_PARITY_EN
    // Bad parity on ch2 drops the frame and returns to HUNT
    applyStimulus(mkRow(0, 1, 1, 0, 8'h11, 0, f1, 1, 0), idx++);
    applyStimulus(mkRow(0, 1, 0, 0, 8'h22, 0, f1, 1, 0), idx++);
    t = mkRow(0, 1, 0, 0, 8'h33, 0, f1, 0, 0);
    t.badp = 1'b1;
    t.ep   = 1'b1;
    applyStimulus(t, idx++);
    t = mkRow(0, 1, 0, 0, 8'h44, 0, f1, 0, 0);
    t.ep = 1'b1;
    applyStimulus(t, idx++);
    t = mkRow(0, 1, 1, 0, 8'h15, 0, f1, 1, 0);
    t.ep = 1'b1;
    applyStimulus(t, idx++);
    t = mkRow(0, 1, 0, 0, 8'h26, 0, f1, 1, 0);
    t.ep = 1'b1;
    applyStimulus(t, idx++);
    t = mkRow(0, 1, 0, 0, 8'h37, 0, f1, 1, 0);
    t.ep = 1'b1;
    applyStimulus(t, idx++);
    t = mkRow(0, 1, 0, 0, 8'h48, 1, 32'h48372615, 1, 0);
    t.ep = 1'b1;
    applyStimulus(t, idx++);
`else
    t = mkRow(0, 0, 0, 0, 8'h00, 0, f1, 1, 0);
    applyStimulus(t, idx++);
`endif

    applyStimulus(mkRow(0, 0, 0, 0, 8'h00, 0, out_data, locked, frame_err), idx++);
    compareVal("scoreboard leftover frames", pending.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
